// File: rtl/iter_muldiv_alu.sv
// Registered EX-stage ALU with an iterative multiply/divide engine and HI/LO registers.
// Optional build macro ALU_SINGLE_CYCLE_MUL_EN: MULT/MULTU use a one-cycle full multiplier.
module iter_muldiv_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             div0_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd3;
  localparam logic [4:0] OP_SLTU  = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_XOR   = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd9;
  localparam logic [4:0] OP_SRL   = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             zdiv_q, zdiv_d;

  logic             valid_d, zero_d, overflow_d, div0_d;
  logic [WIDTH-1:0] result_d, hi_d, lo_d;

  logic             accept_c, is_iter_c, is_mul1_c;
  logic [PW-1:0]    mul_full_c;

  assign accept_c = valid_i && ready_o;

  // Single-cycle ALU
  logic [WIDTH-1:0] alu_res_c, sum_c, diff_c;
  logic             alu_ovf_c;
  logic [SHW-1:0]   shamt_c;

  assign sum_c   = src0_i + src1_i;
  assign diff_c  = src0_i - src1_i;
  assign shamt_c = src0_i[SHW-1:0];

  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (op_i)
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (src0_i[WIDTH-1] == src1_i[WIDTH-1]) && (sum_c[WIDTH-1] != src0_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (src0_i[WIDTH-1] != src1_i[WIDTH-1]) && (diff_c[WIDTH-1] != src0_i[WIDTH-1]);
      end
      OP_SLT:  alu_res_c = WIDTH'($signed(src0_i) < $signed(src1_i));
      OP_SLTU: alu_res_c = WIDTH'(src0_i < src1_i);
      OP_AND:  alu_res_c = src0_i & src1_i;
      OP_OR:   alu_res_c = src0_i | src1_i;
      OP_NOR:  alu_res_c = ~(src0_i | src1_i);
      OP_XOR:  alu_res_c = src0_i ^ src1_i;
      OP_SLL:  alu_res_c = src1_i << shamt_c;
      OP_SRL:  alu_res_c = src1_i >> shamt_c;
      OP_SRA:  alu_res_c = WIDTH'($signed(src1_i) >>> shamt_c);
      default: alu_res_c = '0;
    endcase
  end

`ifdef ALU_SINGLE_CYCLE_MUL_EN
  logic [PW-1:0] mul_a_c, mul_b_c;

  assign is_iter_c  = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign is_mul1_c  = (op_i == OP_MULT) || (op_i == OP_MULTU);
  // Sign- or zero-extend to 2*WIDTH so one unsigned product serves both opcodes
  assign mul_a_c    = {{WIDTH{src0_i[WIDTH-1] & (op_i == OP_MULT)}}, src0_i};
  assign mul_b_c    = {{WIDTH{src1_i[WIDTH-1] & (op_i == OP_MULT)}}, src1_i};
  assign mul_full_c = mul_a_c * mul_b_c;
`else
  assign is_iter_c  = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                      (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign is_mul1_c  = 1'b0;
  assign mul_full_c = '0;
`endif

  // Operand magnitudes for the iterative engine
  logic             op_signed_c, a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;

  assign op_signed_c = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg_c     = op_signed_c & src0_i[WIDTH-1];
  assign b_neg_c     = op_signed_c & src1_i[WIDTH-1];
  assign a_mag_c     = a_neg_c ? -src0_i : src0_i;
  assign b_mag_c     = b_neg_c ? -src1_i : src1_i;

  // One shift-add or restoring-divide iteration; prod_q holds {acc/rem, multiplier/quotient}
  logic [WIDTH:0] mul_sum_c, div_sh_c, div_trial_c;
  logic [PW-1:0]  mul_step_c, div_step_c;

  assign mul_sum_c   = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, opd_q} : '0);
  assign mul_step_c  = {mul_sum_c, prod_q[WIDTH-1:1]};
  assign div_sh_c    = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
  assign div_trial_c = div_sh_c - {1'b0, opd_q};
  assign div_step_c  = div_trial_c[WIDTH]
                     ? {div_sh_c[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                     : {div_trial_c[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  // Sign fix-up applied in DONE
  logic [WIDTH-1:0] fix_hi_c, fix_lo_c;
  logic [PW-1:0]    prod_fix_c;

  assign prod_fix_c = neg_q ? -prod_q : prod_q;

  always_comb begin
    fix_hi_c = prod_fix_c[PW-1:WIDTH];
    fix_lo_c = prod_fix_c[WIDTH-1:0];
    if (is_div_q) begin
      if (zdiv_q) begin
        fix_hi_c = a_raw_q;
        fix_lo_c = '1;
      end else begin
        fix_lo_c = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        fix_hi_c = rem_neg_q ? -prod_q[PW-1:WIDTH] : prod_q[PW-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c && is_iter_c) state_d = S_BUSY;
      S_BUSY: begin
        if (flush_i)                 state_d = S_IDLE;
        else if (cnt_q == CW'(1))    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    opd_d      = opd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    zdiv_d     = zdiv_q;
    valid_d    = 1'b0;
    result_d   = result_o;
    hi_d       = hi_o;
    lo_d       = lo_o;
    overflow_d = overflow_o;
    div0_d     = div0_o;
    case (state_q)
      S_IDLE: begin
        if (accept_c && is_iter_c) begin
          cnt_d     = CW'(WIDTH);
          prod_d    = {{WIDTH{1'b0}}, a_mag_c};
          opd_d     = b_mag_c;
          a_raw_d   = src0_i;
          is_div_d  = (op_i == OP_DIV) || (op_i == OP_DIVU);
          neg_d     = a_neg_c ^ b_neg_c;
          rem_neg_d = a_neg_c;
          zdiv_d    = (src1_i == '0);
        end else if (accept_c) begin
          valid_d    = 1'b1;
          result_d   = alu_res_c;
          overflow_d = alu_ovf_c;
          div0_d     = 1'b0;
          if (is_mul1_c) begin
            hi_d     = mul_full_c[PW-1:WIDTH];
            lo_d     = mul_full_c[WIDTH-1:0];
            result_d = mul_full_c[WIDTH-1:0];
          end
        end
      end
      S_BUSY: begin
        if (!flush_i) begin
          cnt_d  = cnt_q - CW'(1);
          prod_d = is_div_q ? div_step_c : mul_step_c;
        end
      end
      S_DONE: begin
        if (!flush_i) begin
          valid_d    = 1'b1;
          hi_d       = fix_hi_c;
          lo_d       = fix_lo_c;
          result_d   = fix_lo_c;
          overflow_d = 1'b0;
          div0_d     = is_div_q & zdiv_q;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  assign zero_d = (result_d == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      prod_q     <= '0;
      opd_q      <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      zdiv_q     <= 1'b0;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      result_o   <= '0;
      hi_o       <= '0;
      lo_o       <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
      div0_o     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      opd_q      <= opd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      zdiv_q     <= zdiv_d;
      ready_o    <= (state_d == S_IDLE);
      valid_o    <= valid_d;
      result_o   <= result_d;
      hi_o       <= hi_d;
      lo_o       <= lo_d;
      zero_o     <= zero_d;
      overflow_o <= overflow_d;
      div0_o     <= div0_d;
    end
  end

endmodule

// File: doc/iter_muldiv_alu.md
Name: iter_muldiv_alu

Overview:
- Parametrised, registered successor to the pipeline's combinational ALU. Adds an iterative multiply/divide engine with architectural HI/LO registers.
- Sits in the EX stage of the pipelined CPU. Single-cycle ops return next cycle; MULT/DIV ops hold the stage through a valid/ready handshake until done.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and at least 8.
- SHW, 5, shift-amount bits used from src0_i; equals log2(WIDTH).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  operation request.
- ready_o  out  1  block can accept a request; high only in IDLE.
- op_i  in  5  opcode: 0 NOP, 1 ADD, 2 SUB, 3 SLT, 4 SLTU, 5 AND, 6 OR, 7 NOR, 8 XOR, 9 SLL, 10 SRL, 11 SRA, 12 MULT, 13 MULTU, 14 DIV, 15 DIVU; 16–31 behave as NOP.
- src0_i  in  WIDTH  rs operand, or shift amount in bits [SHW-1:0].
- src1_i  in  WIDTH  rt operand or extended immediate.
- flush_i  in  1  abort an in-flight MULT/DIV.
- valid_o  out  1  one-cycle pulse; the result outputs are valid in this cycle.
- result_o  out  WIDTH  result; equals LO for MULT/DIV ops.
- hi_o  out  WIDTH  architectural HI register.
- lo_o  out  WIDTH  architectural LO register.
- zero_o  out  1  result_o == 0; registered with result_o.
- overflow_o  out  1  signed overflow, ADD/SUB only.
- div0_o  out  1  DIV/DIVU with divisor 0.

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE; ready_o=1; valid_o=0; result_o, hi_o, lo_o = 0; zero_o=1; overflow_o=0; div0_o=0.
- A request is accepted on an edge where valid_i && ready_o.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, single-cycle op accepted: stay in IDLE. valid_o=1 on the next cycle with result_o/flags updated. Back-to-back accepts are allowed every cycle.
  - IDLE, MULT/DIV op accepted: go to BUSY; load the counter with WIDTH; ready_o drops the next cycle.
  - BUSY: one iteration per cycle; the counter decrements; at counter==1 go to DONE.
  - DONE: apply the sign fix-up; write HI/LO; valid_o=1 for one cycle; return to IDLE. Latency is accept edge + WIDTH+1 edges.
  - flush_i in BUSY or DONE: next state IDLE, no valid_o, HI/LO unchanged. flush_i in IDLE has no effect, and a same-cycle request is still accepted.
- Single-cycle ops follow the existing ALU semantics:
  - SLT is a signed compare; SLTU is unsigned.
  - SLL/SRL/SRA use src0_i[SHW-1:0] on src1_i; SRA fills with src1_i[WIDTH-1].
  - ADD/SUB wrap modulo 2^WIDTH; overflow_o is the two's-complement overflow. No other op asserts overflow_o.
  - NOP: result_o=0, valid_o=1.
  - HI/LO are untouched by single-cycle ops.
- MULT/MULTU:
  - Radix-2 shift-add on operand magnitudes, producing {HI,LO} = 2*WIDTH-bit product.
  - MULT negates the product when the operand signs differ.
- DIV/DIVU:
  - Restoring division on magnitudes: LO = quotient, HI = remainder.
  - DIV quotient sign = src0 sign XOR src1 sign; remainder sign follows the dividend.
  - Signed MIN / -1: LO = MIN, HI = 0, overflow_o = 0.
  - Divisor 0: LO = all ones, HI = src0_i, div0_o = 1. This takes full latency, with no early exit.
- Operands are captured at accept; src*_i may change while in BUSY.
- div0_o and overflow_o are valid only with valid_o and are cleared on the next valid_o.
- Reset mid-operation: immediate IDLE per the reset values above.

Optional Feature:
- Macro ALU_SINGLE_CYCLE_MUL_EN.
- When defined: MULT/MULTU compute {HI,LO} with a full-width multiplier in the accept cycle. They behave like single-cycle ops: valid_o next cycle, no BUSY, ready_o stays 1. DIV/DIVU are unchanged.
- When undefined: MULT/MULTU use the iterative path with WIDTH+1 latency.

Test Plan:
- ADD 0x7FFFFFFF + 1, then SUB 0x80000000 - 1, back-to-back -> valid_o on two consecutive cycles; results 0x80000000 and 0x7FFFFFFF; overflow_o=1 both times.
- SRA src1=0x80000000, shamt 4 -> 0xF8000000. SLT -1 < 1 -> 1. SLTU 0xFFFFFFFF < 1 -> 0 with zero_o=1.
- MULT -3 × 7 -> ready_o low for 33 cycles; valid_o at accept+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100, div0_o=1. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU 100 / 7 flushed at BUSY cycle 10 -> no valid_o; HI/LO hold their prior values; ready_o=1 next cycle; a new ADD is then accepted normally.
- rst_n_i low mid-MULT (asynchronous, between edges) -> all outputs return to reset values immediately; after release, MULTU 3×5 -> HI=0, LO=15.
